// File: rtl/fnd_scan_ctrl_if.sv
// Register-file write port of the 7-segment scan controller.
// The host drives one digit entry per strobe.
interface fnd_scan_ctrl_if #(
    parameter int unsigned AW = 3
) ();
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          wr_blank;

    modport master (output wr_en, wr_addr, wr_data, wr_blank);
    modport slave  (input  wr_en, wr_addr, wr_data, wr_blank);
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for common-enable 7-segment digits
// sharing one decoder; blanks all digits for a guard interval at each switch.
module fnd_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned AW         = 3,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned GUARD_CYC  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    fnd_scan_ctrl_if.slave        i_wr,
    output logic [3:0]            o_fnd_din,
    output logic [NUM_DIGITS-1:0] o_digit_sel,
    output logic [AW-1:0]         o_cur_digit,
    output logic                  o_frame_done
);

    localparam int unsigned CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEPTH = 2 ** AW;

    localparam logic [CW-1:0]         GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0]         SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [AW-1:0]         DIGIT_LAST = AW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF    = '1;
    localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic [CW-1:0]         r_cnt,        w_cnt_nxt;
    logic [AW-1:0]         r_cur_digit,  w_cur_digit_nxt;
    logic [3:0]            r_fnd_din,    w_fnd_din_nxt;
    logic [NUM_DIGITS-1:0] r_digit_sel,  w_digit_sel_nxt;
    logic                  r_frame_done, w_frame_done_nxt;

    // Entry layout {blank, value}; sized to the full address space so any
    // cur_digit indexes a real entry, writes beyond NUM_DIGITS are dropped.
    logic [4:0] r_rf [DEPTH];
    logic [4:0] w_entry;
    logic       w_wr_ok;

    assign w_entry = r_rf[r_cur_digit];
    assign w_wr_ok = i_wr.wr_en && (32'(i_wr.wr_addr) < NUM_DIGITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_rf[i] <= 5'b1_0000;
            end
        end else if (w_wr_ok) begin
            r_rf[i_wr.wr_addr] <= {i_wr.wr_blank, i_wr.wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_GUARD;
            r_cnt        <= '0;
            r_cur_digit  <= '0;
            r_fnd_din    <= '0;
            r_digit_sel  <= SEL_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cur_digit  <= w_cur_digit_nxt;
            r_fnd_din    <= w_fnd_din_nxt;
            r_digit_sel  <= w_digit_sel_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Slot sequencing: the entry is sampled only on the guard-to-drive edge.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_cur_digit_nxt  = r_cur_digit;
        w_fnd_din_nxt    = r_fnd_din;
        w_digit_sel_nxt  = r_digit_sel;
        w_frame_done_nxt = 1'b0;

        if (!i_en) begin
            w_state_nxt     = S_GUARD;
            w_cnt_nxt       = '0;
            w_digit_sel_nxt = SEL_OFF;
        end else begin
            w_cnt_nxt = r_cnt + CW'(1);
            case (r_state)
                S_GUARD: begin
                    w_digit_sel_nxt = SEL_OFF;
                    if (r_cnt == GUARD_LAST) begin
                        w_state_nxt     = S_DRIVE;
                        w_fnd_din_nxt   = w_entry[3:0];
                        w_digit_sel_nxt = w_entry[4] ? SEL_OFF : ~(SEL_ONE << r_cur_digit);
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == SLOT_LAST) begin
                        w_state_nxt      = S_GUARD;
                        w_cnt_nxt        = '0;
                        w_digit_sel_nxt  = SEL_OFF;
                        w_cur_digit_nxt  = (r_cur_digit == DIGIT_LAST) ? '0 : r_cur_digit + AW'(1);
                        w_frame_done_nxt = (r_cur_digit == DIGIT_LAST);
                    end
                end
            endcase
        end
    end

    assign o_fnd_din    = r_fnd_din;
    assign o_digit_sel  = r_digit_sel;
    assign o_cur_digit  = r_cur_digit;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: directed scenarios plus random traffic, every
// cycle compared against a slot-level behavioural model.
module tb_fnd_scan_ctrl;

    localparam int ND = 4;
    localparam int AW = 3;
    localparam int SD = 8;
    localparam int GC = 2;

    logic          clk;
    logic          rst;
    logic          en;
    logic [3:0]    fnd;
    logic [ND-1:0] sel;
    logic [AW-1:0] cur;
    logic          fd;

    fnd_scan_ctrl_if #(.AW(AW)) bus ();

    fnd_scan_ctrl #(
        .NUM_DIGITS (ND),
        .AW         (AW),
        .SCAN_DIV   (SD),
        .GUARD_CYC  (GC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (en),
        .i_wr         (bus.slave),
        .o_fnd_din    (fnd),
        .o_digit_sel  (sel),
        .o_cur_digit  (cur),
        .o_frame_done (fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: digit contents, position inside the current slot, and whether
    // the digit sampled at the start of its drive window is lit.
    int       m_val   [ND];
    bit       m_blank [ND];
    int       m_digit;
    int       m_slot;
    bit       m_lit;
    bit       m_fd;
    int       m_fnd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit wr;
        int wa;
        if (rst) begin
            for (int i = 0; i < ND; i++) begin
                m_val[i]   = 0;
                m_blank[i] = 1'b1;
            end
            m_digit = 0; m_slot = 0; m_lit = 1'b0; m_fnd = 0; m_fd = 1'b0;
            return;
        end
        wa = int'(bus.wr_addr);
        wr = bus.wr_en && (wa < ND);
        m_fd = 1'b0;
        if (!en) begin
            m_lit  = 1'b0;
            m_slot = 0;
        end else if (m_slot == GC - 1) begin
            m_fnd  = m_val[m_digit];
            m_lit  = !m_blank[m_digit];
            m_slot = m_slot + 1;
        end else if (m_slot == SD - 1) begin
            m_slot = 0;
            m_lit  = 1'b0;
            m_fd   = (m_digit == ND - 1);
            m_digit = (m_digit + 1) % ND;
        end else begin
            m_slot = m_slot + 1;
        end
        if (wr) begin
            m_val[wa]   = int'(bus.wr_data);
            m_blank[wa] = bus.wr_blank;
        end
    endtask

    task automatic check_outputs();
        logic [ND-1:0] es;
        es = m_lit ? ~(ND'(1) << m_digit) : '1;
        chk("digit_sel",  32'(sel), 32'(es));
        chk("fnd_din",    32'(fnd), 32'(m_fnd));
        chk("cur_digit",  32'(cur), 32'(m_digit));
        chk("frame_done", 32'(fd),  32'(m_fd));
        chk("one_low_max", 32'($countones(~sel) <= 1), 32'(1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic write(input int a, input int d, input bit b);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = AW'(a);
        bus.wr_data  = 4'(d);
        bus.wr_blank = b;
        tick();
        bus.wr_en    = 1'b0;
    endtask

    task automatic wait_slot(input int d, input int t);
        int budget = 200;
        while (!(m_digit == d && m_slot == t) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("wait_timeout", 32'(m_slot), 32'(t));
    endtask

    initial begin
        int cnt;
        rst = 1'b1; en = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_blank = 1'b0;

        // Reset and dark scan
        tick(); tick();
        chk("reset_sel", 32'(sel), 32'(4'hF));
        chk("reset_fnd", 32'(fnd), 32'(0));
        chk("reset_cur", 32'(cur), 32'(0));
        chk("reset_fd",  32'(fd),  32'(0));
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (fd) cnt++;
            if (i == 7)  chk("dark_cur1", 32'(cur), 32'(1));
            if (sel != 4'hF) chk("dark_sel", 32'(sel), 32'(4'hF));
        end
        chk("dark_fd_count", 32'(cnt), 32'(2));

        // Lit digits
        write(0, 4'h1, 1'b0); write(1, 4'hA, 1'b0);
        write(2, 4'h5, 1'b0); write(3, 4'hF, 1'b0);
        wait_slot(0, 0);
        wait_slot(0, 1); chk("guard_sel", 32'(sel), 32'(4'hF));
        wait_slot(0, 2); chk("d0_sel", 32'(sel), 32'(4'b1110)); chk("d0_fnd", 32'(fnd), 32'(4'h1));
        wait_slot(1, 7); chk("d1_sel", 32'(sel), 32'(4'b1101)); chk("d1_fnd", 32'(fnd), 32'(4'hA));
        wait_slot(2, 3); chk("d2_sel", 32'(sel), 32'(4'b1011)); chk("d2_fnd", 32'(fnd), 32'(4'h5));
        wait_slot(3, 4); chk("d3_sel", 32'(sel), 32'(4'b0111)); chk("d3_fnd", 32'(fnd), 32'(4'hF));

        // Blank digit 2
        write(2, 4'h5, 1'b1);
        wait_slot(2, 5); chk("blank_sel", 32'(sel), 32'(4'hF));
        wait_slot(3, 5); chk("after_blank_sel", 32'(sel), 32'(4'b0111));

        // Write during drive, then on the sampling edge
        wait_slot(1, 4);
        write(1, 4'h7, 1'b0);
        chk("drive_write_hold", 32'(fnd), 32'(4'hA));
        wait_slot(1, 7); chk("drive_write_hold_end", 32'(fnd), 32'(4'hA));
        wait_slot(2, 0); wait_slot(1, 3); chk("drive_write_next", 32'(fnd), 32'(4'h7));
        wait_slot(1, 1);
        write(1, 4'h3, 1'b0);
        chk("edge_write_old", 32'(fnd), 32'(4'h7));
        wait_slot(2, 0); wait_slot(1, 3); chk("edge_write_next", 32'(fnd), 32'(4'h3));

        // Enable pause in digit 3 drive
        wait_slot(3, 4);
        en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("pause_sel", 32'(sel), 32'(4'hF));
            chk("pause_cur", 32'(cur), 32'(3));
        end
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 2)       chk("resume_guard", 32'(sel), 32'(4'hF));
            else if (i < 8)  chk("resume_lit",   32'(sel), 32'(4'b0111));
            else begin
                chk("resume_fd",  32'(fd),  32'(1));
                chk("resume_cur", 32'(cur), 32'(0));
            end
        end

        // Out-of-range write and mid-slot reset
        write(5, 4'h9, 1'b0);
        wait_slot(1, 3); chk("oob_d1", 32'(fnd), 32'(4'h3));
        wait_slot(0, 3); chk("oob_d0", 32'(fnd), 32'(4'h1));
        wait_slot(3, 5);
        rst = 1'b1;
        tick();
        chk("mid_rst_sel", 32'(sel), 32'(4'hF));
        chk("mid_rst_fnd", 32'(fnd), 32'(0));
        chk("mid_rst_cur", 32'(cur), 32'(0));
        chk("mid_rst_fd",  32'(fd),  32'(0));
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sel != 4'hF) cnt++;
        end
        chk("post_rst_dark", 32'(cnt), 32'(0));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.wr_en    = ($urandom_range(0, 7) == 0);
            bus.wr_addr  = AW'($urandom_range(0, 7));
            bus.wr_data  = 4'($urandom);
            bus.wr_blank = ($urandom_range(0, 3) == 0);
            en           = ($urandom_range(0, 63) != 0);
            rst          = ($urandom_range(0, 499) == 0);
            tick();
        end
        bus.wr_en = 1'b0; en = 1'b1; rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
